// File: rtl/l2_cache_replacement.sv
// L2 replacement-state tracker: per-set PLRUm or tree-PLRU bits plus per-way lock bits,
// a two-stage victim/promote pipeline and an INIT/FLUSH sweep that clears all state.
module l2_cache_replacement #(
  parameter int NUM_SETS        = 128,
  parameter int NUM_WAYS        = 8,
  parameter int POLICY          = 0,
  parameter int SET_INDEX_WIDTH = $clog2(NUM_SETS),
  parameter int WAY_INDEX_WIDTH = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fill_en,
  input  logic [SET_INDEX_WIDTH-1:0] fill_set,
  output logic [WAY_INDEX_WIDTH-1:0] fill_way,
  output logic                       fill_valid,
  output logic                       fill_all_locked,
  input  logic                       access_en,
  input  logic [SET_INDEX_WIDTH-1:0] access_set,
  input  logic                       access_update_en,
  input  logic [WAY_INDEX_WIDTH-1:0] access_update_way,
  input  logic                       lock_en,
  input  logic                       lock_value,
  input  logic                       flush_en,
  output logic                       ready
);

  localparam int REPL_W      = (POLICY == 0) ? NUM_WAYS : ((NUM_WAYS > 1) ? NUM_WAYS - 1 : 1);
  localparam int TREE_LEVELS = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 0;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e                     state, state_next;
  logic [SET_INDEX_WIDTH-1:0] sweep_idx, sweep_next;
  logic                       sweep_active;

  logic [REPL_W-1:0]          repl_bits [NUM_SETS];
  logic [NUM_WAYS-1:0]        lock_bits [NUM_SETS];

  logic                       req_ok, req_fill, req_access;
  logic                       p_fill, p_access, p_lock, p_lock_value;
  logic [SET_INDEX_WIDTH-1:0] p_set;

  logic [REPL_W-1:0]          cur_repl, new_repl;
  logic [NUM_WAYS-1:0]        cur_lock, new_lock, used, promote_oh;
  logic                       all_locked, tree_hit, do_promote;
  logic [WAY_INDEX_WIDTH-1:0] lowest_unlocked, victim, promote_way;

  // ---------------------------------------------------------------------------
  // Sweep state machine
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering in simulation.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_INIT;
      sweep_idx <= '0;
    end else begin
      state     <= state_next;
      sweep_idx <= sweep_next;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    sweep_next   = sweep_idx;
    ready        = 1'b0;
    sweep_active = 1'b0;
    case (state)
      ST_INIT, ST_FLUSH: begin
        sweep_active = 1'b1;
        if (sweep_idx == SET_INDEX_WIDTH'(NUM_SETS - 1)) begin
          state_next = ST_RUN;
          sweep_next = '0;
        end else begin
          sweep_next = sweep_idx + 1'b1;
        end
      end
      ST_RUN: begin
        ready = 1'b1;
        if (flush_en) begin
          state_next = ST_FLUSH;
          sweep_next = '0;
        end
      end
      default: state_next = ST_INIT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request stage: fill wins over access; a flush request drops both.
  // ---------------------------------------------------------------------------
  assign req_ok     = ready & ~flush_en;
  assign req_fill   = req_ok & fill_en;
  assign req_access = req_ok & access_en & ~fill_en;

  always_ff @(posedge clk) begin
    if (!reset) begin
      p_fill       <= 1'b0;
      p_access     <= 1'b0;
      p_lock       <= 1'b0;
      p_lock_value <= 1'b0;
      p_set        <= '0;
    end else begin
      p_fill       <= req_fill;
      p_access     <= req_access;
      p_lock       <= lock_en & (req_fill | req_access);
      p_lock_value <= lock_value;
      if (req_fill) begin
        p_set <= fill_set;
      end else if (req_access) begin
        p_set <= access_set;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result stage: victim selection reads storage directly, so a request issued
  // while the same set is being written sees the written value one cycle later.
  // ---------------------------------------------------------------------------
  assign cur_repl   = repl_bits[p_set];
  assign cur_lock   = lock_bits[p_set];
  assign all_locked = &cur_lock;

  always_comb begin
    lowest_unlocked = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!cur_lock[w]) lowest_unlocked = WAY_INDEX_WIDTH'(w);
    end

    victim   = lowest_unlocked;
    used     = NUM_WAYS'(cur_repl) | cur_lock;
    tree_hit = 1'b0;
    if (POLICY == 0) begin
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
        if (!used[w]) victim = WAY_INDEX_WIDTH'(w);
      end
    end else begin
      // Exactly one leaf matches every node bit on its path from the root.
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
        tree_hit = 1'b1;
        for (int l = 0; l < TREE_LEVELS; l++) begin
          if (cur_repl[(1 << l) - 1 + (w >> (TREE_LEVELS - l))] !=
              1'((w >> (TREE_LEVELS - 1 - l)) & 1)) tree_hit = 1'b0;
        end
        if (tree_hit && !cur_lock[w]) victim = WAY_INDEX_WIDTH'(w);
      end
    end
  end

  assign fill_valid      = p_fill;
  assign fill_all_locked = p_fill & all_locked;
  assign fill_way        = (p_fill && !all_locked) ? victim : '0;

  assign do_promote  = p_fill ? ~all_locked : (p_access & access_update_en & ready);
  assign promote_way = p_fill ? victim : access_update_way;
  assign promote_oh  = NUM_WAYS'(1) << promote_way;

  always_comb begin
    new_lock = cur_lock;
    if (p_lock) new_lock[promote_way] = p_lock_value;

    new_repl = cur_repl;
    if (POLICY == 0) begin
      if (&(NUM_WAYS'(cur_repl) | cur_lock | promote_oh)) begin
        new_repl = REPL_W'(promote_oh);
      end else begin
        new_repl = cur_repl | REPL_W'(promote_oh);
      end
    end else begin
      // Each node on the promoted way's path is turned to point away from it.
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (promote_way == WAY_INDEX_WIDTH'(w)) begin
          for (int l = 0; l < TREE_LEVELS; l++) begin
            new_repl[(1 << l) - 1 + (w >> (TREE_LEVELS - l))] =
              ~1'((w >> (TREE_LEVELS - 1 - l)) & 1);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State storage
  // ---------------------------------------------------------------------------
  // NOTE: the arrays carry no reset; the INIT sweep clears one set per cycle,
  // which keeps them plain enabled flops with no wide reset network.
  always_ff @(posedge clk) begin
    if (sweep_active) begin
      repl_bits[sweep_idx] <= '0;
      lock_bits[sweep_idx] <= '0;
    end else if (do_promote) begin
      repl_bits[p_set] <= new_repl;
      lock_bits[p_set] <= new_lock;
    end
  end

  // ---------------------------------------------------------------------------
  // Interface protocol checks
  // ---------------------------------------------------------------------------
  assert property (@(posedge clk) disable iff (!reset)
                   access_update_en |-> $past(access_en & ready));

  assert property (@(posedge clk) disable iff (!reset)
                   !(fill_en && flush_en));

endmodule

// File: tb/tb_l2_cache_replacement.sv
// Directed bench for l2_cache_replacement: 8-way PLRUm (128 sets), 4-way PLRUm and
// 4-way tree-PLRU instances share one stimulus stream; each scenario checks one instance.
module tb_l2_cache_replacement;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       fill_en, access_en, access_update_en, lock_en, lock_value, flush_en;
  logic [6:0] fill_set, access_set;
  logic [2:0] upd_way;

  logic [2:0] a_way;
  logic       a_valid, a_locked, a_ready;
  logic [1:0] b_way;
  logic       b_valid, b_locked, b_ready;
  logic [1:0] c_way;
  logic       c_valid, c_locked, c_ready;

  int n_checks = 0;
  int n_fail   = 0;
  int plrum_seq [6] = '{0, 1, 2, 3, 0, 1};

  l2_cache_replacement #(.NUM_SETS(128), .NUM_WAYS(8), .POLICY(0)) u_dut_a (
    .clk(clk), .reset(reset),
    .fill_en(fill_en), .fill_set(fill_set), .fill_way(a_way),
    .fill_valid(a_valid), .fill_all_locked(a_locked),
    .access_en(access_en), .access_set(access_set),
    .access_update_en(access_update_en), .access_update_way(upd_way),
    .lock_en(lock_en), .lock_value(lock_value), .flush_en(flush_en), .ready(a_ready)
  );

  l2_cache_replacement #(.NUM_SETS(16), .NUM_WAYS(4), .POLICY(0)) u_dut_b (
    .clk(clk), .reset(reset),
    .fill_en(fill_en), .fill_set(fill_set[3:0]), .fill_way(b_way),
    .fill_valid(b_valid), .fill_all_locked(b_locked),
    .access_en(access_en), .access_set(access_set[3:0]),
    .access_update_en(access_update_en), .access_update_way(upd_way[1:0]),
    .lock_en(lock_en), .lock_value(lock_value), .flush_en(flush_en), .ready(b_ready)
  );

  l2_cache_replacement #(.NUM_SETS(16), .NUM_WAYS(4), .POLICY(1)) u_dut_c (
    .clk(clk), .reset(reset),
    .fill_en(fill_en), .fill_set(fill_set[3:0]), .fill_way(c_way),
    .fill_valid(c_valid), .fill_all_locked(c_locked),
    .access_en(access_en), .access_set(access_set[3:0]),
    .access_update_en(access_update_en), .access_update_way(upd_way[1:0]),
    .lock_en(lock_en), .lock_value(lock_value), .flush_en(flush_en), .ready(c_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fill_en          = 1'b0;
    access_en        = 1'b0;
    access_update_en = 1'b0;
    lock_en          = 1'b0;
    lock_value       = 1'b0;
    flush_en         = 1'b0;
    fill_set         = '0;
    access_set       = '0;
    upd_way          = '0;
  endtask

  task automatic fill_req(input logic [6:0] set, input logic lk, input logic lv);
    fill_en    = 1'b1;
    fill_set   = set;
    lock_en    = lk;
    lock_value = lv;
  endtask

  task automatic wait_ready(input string tag, input int exp_cycles);
    int cnt = 0;
    while (!a_ready && cnt < 1000) begin
      step();
      cnt++;
    end
    check(tag, cnt, exp_cycles);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    reset = 1'b0;
    step();
    reset = 1'b1;

    // Reset state and INIT sweep length
    check("reset_ready", a_ready, 0);
    check("reset_fill_valid", a_valid, 0);
    check("reset_fill_way", a_way, 0);
    check("reset_all_locked", a_locked, 0);
    wait_ready("init_sweep_cycles", 128);

    // First fill after init
    fill_req(7'd5, 1'b0, 1'b0);
    check("fill_request_cycle_valid", a_valid, 0);
    step();
    idle_inputs();
    check("first_fill_valid", a_valid, 1);
    check("first_fill_way", a_way, 0);

    // 4-way PLRUm back-to-back fills to set 3, including the wrap
    fill_req(7'd3, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 5) idle_inputs();
      check($sformatf("plrum4_fill%0d_way", i), b_way, plrum_seq[i]);
    end
    check("plrum4_fill_valid", b_valid, 1);

    // Lock every way of set 7, then the ninth fill finds none free
    fill_req(7'd7, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) begin
      step();
      if (i == 8) idle_inputs();
      check($sformatf("lock_fill%0d_all_locked", i), a_locked, (i == 8) ? 1 : 0);
      check($sformatf("lock_fill%0d_way", i), a_way, (i == 8) ? 0 : i);
    end

    // Unlock way 2 through a hit update; next fill must pick it
    access_en  = 1'b1;
    access_set = 7'd7;
    lock_en    = 1'b1;
    lock_value = 1'b0;
    step();
    idle_inputs();
    access_update_en = 1'b1;
    upd_way          = 3'd2;
    step();
    idle_inputs();
    fill_req(7'd7, 1'b0, 1'b0);
    step();
    idle_inputs();
    check("unlock_refill_way", a_way, 2);
    check("unlock_refill_all_locked", a_locked, 0);

    // Lock with an access but no update is discarded
    access_en  = 1'b1;
    access_set = 7'd7;
    lock_en    = 1'b1;
    lock_value = 1'b1;
    step();
    idle_inputs();
    upd_way = 3'd2;
    step();
    idle_inputs();
    fill_req(7'd7, 1'b0, 1'b0);
    step();
    idle_inputs();
    check("discarded_lock_way", a_way, 2);
    check("discarded_lock_all_locked", a_locked, 0);

    // Fill and access in the same cycle: fill serviced, access update ignored
    fill_req(7'd9, 1'b0, 1'b0);
    step();
    idle_inputs();
    check("set9_first_fill_way", a_way, 0);
    fill_req(7'd9, 1'b0, 1'b0);
    access_en  = 1'b1;
    access_set = 7'd4;
    step();
    idle_inputs();
    access_update_en = 1'b1;
    upd_way          = 3'd0;
    check("fill_wins_valid", a_valid, 1);
    check("fill_wins_way", a_way, 1);
    step();
    idle_inputs();
    fill_req(7'd4, 1'b0, 1'b0);
    step();
    idle_inputs();
    check("access_dropped_set4_way", a_way, 0);
    fill_req(7'd9, 1'b0, 1'b0);
    step();
    idle_inputs();
    check("fill_promoted_set9_way", a_way, 2);

    // Tree-PLRU: promote 0 then 2 on set 1; fills then return 1, then 3
    access_en  = 1'b1;
    access_set = 7'd1;
    step();
    access_update_en = 1'b1;
    upd_way          = 3'd0;
    step();
    access_en = 1'b0;
    upd_way   = 3'd2;
    step();
    idle_inputs();
    fill_req(7'd1, 1'b0, 1'b0);
    step();
    check("tree_fill_after_promote_way", c_way, 1);
    step();
    idle_inputs();
    check("tree_back_to_back_way", c_way, 3);

    // Reset in the middle of the INIT sweep restarts it from index 0
    reset = 1'b0;
    step();
    reset = 1'b1;
    for (int i = 0; i < 40; i++) step();
    check("mid_sweep_ready", a_ready, 0);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("mid_sweep_reset_ready", a_ready, 0);
    wait_ready("restart_sweep_cycles", 128);

    // Lock ways 0..2 of set 7, fill once more, then flush
    fill_req(7'd7, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 2) idle_inputs();
      check($sformatf("pre_flush_lock_fill%0d_way", i), a_way, i);
    end
    fill_req(7'd7, 1'b0, 1'b0);
    step();
    idle_inputs();
    check("pre_flush_fill_way", a_way, 3);
    flush_en = 1'b1;
    step();
    idle_inputs();
    check("flush_ready_drop", a_ready, 0);
    wait_ready("flush_sweep_cycles", 128);
    fill_req(7'd7, 1'b0, 1'b0);
    step();
    idle_inputs();
    check("post_flush_fill_way", a_way, 0);
    check("post_flush_all_locked", a_locked, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
